sha_1_pad: RTL and testbench

- Message front-end for the SHA-1 compression core: accepts a byte-oriented message as a stream of 32-bit big-endian words.
- Applies FIPS 180-4 SHA-1 padding: a 0x80 marker, zero fill, then the 64-bit big-endian bit length.
- Delivers 512-bit blocks over the core's Data/Index/Enable/Ready block interface, one block at a time, waiting for the core's Ready pulse before building the next block.

---
 rtl/sha_1_pad.sv | 161 ++++++++++++++++
 tb/tb_sha_1_pad.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_1_pad.sv
// rtl/sha_1_pad.sv - SHA-1 message padder: packs big-endian words into 512-bit blocks for the core
module sha_1_pad (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         in_ready,
    output logic [511:0] Data,
    output logic [63:0]  Index,
    output logic         Enable,
    input  logic         Ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {FILL, PAD, SEND, WAIT} state_t;

    state_t         state_q, state_d;
    logic [4:0]     w_q, w_d;
    logic [60:0]    cnt_q, cnt_d;
    logic [511:0]   data_q, data_d;
    logic [63:0]    index_q, index_d;
    logic           mark_q, mark_d;
    logic           final_q, final_d;
    logic           pend_q, pend_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           wr_en;
    logic [31:0]    wr_word;
    logic [5:0]     shamt;
    logic [31:0]    beat_word;
    logic [60:0]    cnt_base;
    logic [63:0]    len_bits;

    // Final beat: keep the first n bytes and drop the 0x80 marker right after them (no marker when n=4).
    assign shamt     = {in_bytes, 3'b000};
    assign beat_word = (in_data & ~(32'hFFFF_FFFF >> shamt)) | (32'h8000_0000 >> shamt);
    assign cnt_base  = busy_q ? cnt_q : 61'd0;
    assign len_bits  = {cnt_q, 3'b000};

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        index_d = index_q;
        mark_d  = mark_q;
        final_d = final_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_word = 32'd0;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    busy_d = 1'b1;
                    if (!busy_q) index_d = 64'd0;
                    wr_en = 1'b1;
                    w_d   = w_q + 5'd1;
                    if (in_last) begin
                        wr_word = beat_word;
                        cnt_d   = cnt_base + {58'd0, in_bytes};
                        mark_d  = (in_bytes == 3'd4);
                        pend_d  = 1'b1;
                        state_d = PAD;
                    end else begin
                        wr_word = in_data;
                        cnt_d   = cnt_base + 61'd4;
                        if (w_q == 5'd15) begin
                            final_d = 1'b0;
                            state_d = SEND;
                        end
                    end
                end
            end
            PAD: begin
                if (w_q == 5'd16) begin
                    final_d = 1'b0;
                    state_d = SEND;
                end else if (mark_q) begin
                    wr_en   = 1'b1;
                    wr_word = 32'h8000_0000;
                    mark_d  = 1'b0;
                    w_d     = w_q + 5'd1;
                end else if (w_q < 5'd14) begin
                    wr_en = 1'b1;
                    w_d   = w_q + 5'd1;
                end else if (w_q == 5'd14) begin
                    data_d[479:448] = len_bits[63:32];
                    data_d[511:480] = len_bits[31:0];
                    final_d = 1'b1;
                    pend_d  = 1'b0;
                    state_d = SEND;
                end else begin
                    // Word 15 with no room left for the length: zero it and spill into another block.
                    wr_en = 1'b1;
                    w_d   = 5'd16;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (Ready) begin
                    index_d = index_q + 64'd1;
                    w_d     = 5'd0;
                    if (final_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        index_d = 64'd0;
                        cnt_d   = 61'd0;
                        final_d = 1'b0;
                        state_d = FILL;
                    end else if (pend_q) begin
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (wr_en) data_d[{w_q[3:0], 5'b00000} +: 32] = wr_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            w_q     <= 5'd0;
            cnt_q   <= 61'd0;
            data_q  <= 512'd0;
            index_q <= 64'd0;
            mark_q  <= 1'b0;
            final_q <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            index_q <= index_d;
            mark_q  <= mark_d;
            final_q <= final_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = rst && (state_q == FILL);
    assign Data     = data_q;
    assign Index    = index_q;
    assign Enable   = (state_q == SEND);
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_sha_1_pad.sv
// tb/tb_sha_1_pad.sv - directed bench for sha_1_pad with a simple core-side Ready responder
module tb_sha_1_pad;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  in_data = 32'd0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [2:0]   in_bytes = 3'd0;
    logic         in_ready;
    logic [511:0] Data;
    logic [63:0]  Index;
    logic         Enable;
    logic         Ready = 1'b0;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int n_blk = 0;
    int n_done = 0;
    int ready_delay = 2;
    logic resp_en = 1'b1;
    logic [511:0] blk_data [0:15];
    logic [63:0]  blk_index [0:15];
    logic [31:0]  msg [0:15];

    sha_1_pad dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_bytes(in_bytes), .in_ready(in_ready), .Data(Data), .Index(Index),
        .Enable(Enable), .Ready(Ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Enable) begin
            blk_data[n_blk % 16]  <= Data;
            blk_index[n_blk % 16] <= Index;
            n_blk <= n_blk + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    // Core model: Ready pulse ready_delay cycles after Enable; clearing resp_en aborts it.
    always begin
        @(negedge clk);
        if (Enable && resp_en) begin
            for (int i = 0; i < ready_delay && resp_en; i++) @(negedge clk);
            if (resp_en) begin
                Ready = 1'b1;
                @(negedge clk);
                Ready = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb, input logic gate);
        int t;
        if (gate) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        in_data = d; in_last = last; in_bytes = nb; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 3000) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (n_done < target && t < 3000) begin @(negedge clk); t++; end
        checks++;
        if (n_done < target) begin
            errors++;
            $display("FAIL done_timeout: done_count=%0d required %0d", n_done, target);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, Enable, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: {in_ready,Enable,busy,done}=%b required 0000", {in_ready, Enable, busy, done});
        end
        checks++;
        if (Data !== 512'd0 || Index !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: Data=%h Index=%h required 0", Data, Index);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_short(input logic [31:0] d, input logic [2:0] nb, input logic [31:0] w0, input logic [31:0] w15);
        int base = n_blk;
        int dbase = n_done;
        logic [511:0] exp0 = '0;
        exp0[31:0] = w0;
        exp0[511:480] = w15;
        send_beat(d, 1'b1, nb, 1'b0);
        wait_done(dbase + 1);
        checks++;
        if (n_blk - base !== 1) begin
            errors++;
            $display("FAIL short_enables: count=%0d required 1", n_blk - base);
        end
        checks++;
        if (blk_data[base % 16] !== exp0 || blk_index[base % 16] !== 64'd0) begin
            errors++;
            $display("FAIL short_block: Data=%h Index=%0d required Data=%h Index=0", blk_data[base % 16], blk_index[base % 16], exp0);
        end
        checks++;
        if (busy !== 1'b0 || Index !== 64'd0) begin
            errors++;
            $display("FAIL short_after_done: busy=%b Index=%0d required 0 0", busy, Index);
        end
    endtask

    task automatic test_56;
        int base = n_blk;
        int dbase = n_done;
        logic [511:0] exp0 = '0;
        logic [511:0] exp1 = '0;
        for (int i = 0; i < 14; i++) begin
            logic [7:0] b = 8'h61 + 8'(i);
            msg[i] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
            exp0[32*i +: 32] = msg[i];
        end
        exp0[479:448] = 32'h8000_0000;
        exp1[511:480] = 32'h0000_01C0;
        for (int i = 0; i < 14; i++) send_beat(msg[i], i == 13, (i == 13) ? 3'd4 : 3'd0, 1'b0);
        wait_done(dbase + 1);
        checks++;
        if (n_blk - base !== 2) begin
            errors++;
            $display("FAIL m56_enables: count=%0d required 2", n_blk - base);
        end
        checks++;
        if (blk_data[base % 16] !== exp0 || blk_index[base % 16] !== 64'd0) begin
            errors++;
            $display("FAIL m56_block0: Data=%h Index=%0d required %h 0", blk_data[base % 16], blk_index[base % 16], exp0);
        end
        checks++;
        if (blk_data[(base + 1) % 16] !== exp1 || blk_index[(base + 1) % 16] !== 64'd1) begin
            errors++;
            $display("FAIL m56_block1: Data=%h Index=%0d required %h 1", blk_data[(base + 1) % 16], blk_index[(base + 1) % 16], exp1);
        end
    endtask

    // 16 beats, the last carrying last_bytes; randomly gated in_valid.
    task automatic test_long(input logic [2:0] last_bytes, input logic [31:0] w15_0, input logic [31:0] w0_1, input logic [31:0] len);
        int base = n_blk;
        int dbase = n_done;
        logic [511:0] exp0 = '0;
        logic [511:0] exp1 = '0;
        for (int i = 0; i < 16; i++) begin
            msg[i] = 32'h0101_0101 * (i + 1);
            exp0[32*i +: 32] = msg[i];
        end
        exp0[511:480] = w15_0;
        exp1[31:0] = w0_1;
        exp1[511:480] = len;
        ready_delay = 3;
        for (int i = 0; i < 16; i++) send_beat(msg[i], i == 15, (i == 15) ? last_bytes : 3'd0, 1'b1);
        wait_done(dbase + 1);
        ready_delay = 2;
        checks++;
        if (n_blk - base !== 2) begin
            errors++;
            $display("FAIL long%0d_enables: count=%0d required 2", last_bytes, n_blk - base);
        end
        checks++;
        if (blk_data[base % 16] !== exp0 || blk_index[base % 16] !== 64'd0) begin
            errors++;
            $display("FAIL long%0d_block0: Data=%h Index=%0d required %h 0", last_bytes, blk_data[base % 16], blk_index[base % 16], exp0);
        end
        checks++;
        if (blk_data[(base + 1) % 16] !== exp1 || blk_index[(base + 1) % 16] !== 64'd1) begin
            errors++;
            $display("FAIL long%0d_block1: Data=%h Index=%0d required %h 1", last_bytes, blk_data[(base + 1) % 16], blk_index[(base + 1) % 16], exp1);
        end
    endtask

    task automatic test_backpressure;
        int base = n_blk;
        int dbase = n_done;
        int t = 0;
        int bad = 0;
        logic [511:0] exp0 = '0;
        exp0[31:0] = 32'h6162_6380;
        exp0[511:480] = 32'h18;
        ready_delay = 100;
        send_beat(32'h6162_63AA, 1'b1, 3'd3, 1'b0);
        while (n_blk == base && t < 100) begin @(negedge clk); t++; end
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || Enable !== 1'b0 || Data !== exp0 || Index !== 64'd0) bad++;
        end
        checks++;
        if (n_blk == base || bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: enables=%0d unstable_cycles=%0d required 1 0", n_blk - base, bad);
        end
        wait_done(dbase + 1);
        ready_delay = 2;
        checks++;
        if (n_blk - base !== 1) begin
            errors++;
            $display("FAIL backpressure_enables: count=%0d required 1", n_blk - base);
        end
    endtask

    task automatic test_reset_mid;
        int base = n_blk;
        int dbase;
        int t = 0;
        logic [511:0] exp0 = '0;
        exp0[31:0] = 32'h6162_6380;
        exp0[511:480] = 32'h18;
        ready_delay = 1000;
        for (int i = 0; i < 16; i++) send_beat(32'h0101_0101 * (i + 1), i == 15, (i == 15) ? 3'd4 : 3'd0, 1'b0);
        while (n_blk < base + 2 && t < 3000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        resp_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({Enable, done, busy, in_ready} !== 4'b0000 || n_blk != base + 2) begin
            errors++;
            $display("FAIL reset_mid: {Enable,done,busy,in_ready}=%b blocks=%0d required 0000 %0d", {Enable, done, busy, in_ready}, n_blk - base, 2);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resp_en = 1'b1;
        ready_delay = 2;
        base = n_blk;
        dbase = n_done;
        send_beat(32'h6162_6300, 1'b1, 3'd3, 1'b0);
        wait_done(dbase + 1);
        checks++;
        if (n_blk - base !== 1 || blk_data[base % 16] !== exp0 || blk_index[base % 16] !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_next: blocks=%0d Data=%h Index=%0d required 1 %h 0", n_blk - base, blk_data[base % 16], blk_index[base % 16], exp0);
        end
    endtask

    initial begin
        test_reset;
        test_short(32'h6162_63FF, 3'd3, 32'h6162_6380, 32'h0000_0018);
        test_short(32'hDEAD_BEEF, 3'd0, 32'h8000_0000, 32'h0000_0000);
        test_short(32'h6162_ABCD, 3'd2, 32'h6162_8000, 32'h0000_0010);
        test_56;
        test_long(3'd4, 32'h1010_1010, 32'h8000_0000, 32'h0000_0200);
        test_long(3'd3, 32'h1010_1080, 32'h0000_0000, 32'h0000_01F8);
        test_backpressure;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
